// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed 4-digit seven-segment driver with frame-synchronous BCD update
// and optional leading-zero blanking.
module seven_seg_scan #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] BCD,
  input  logic        bcd_valid,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int unsigned PW = $clog2(CLK_DIV);
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d, pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q;
  logic          tick, boundary, lz_blank;
  logic [3:0]    nib;
  logic [6:0]    dec;
  assign tick     = presc_q == PW'(CLK_DIV - 1);
  assign boundary = tick && idx_q == 2'd3;
  assign presc_d  = tick ? '0 : presc_q + 1'b1;
  assign idx_d    = tick ? idx_q + 2'd1 : idx_q;
  // a strobe landing on the boundary bypasses pending so it shows in the very next frame
  always_comb begin
    disp_d     = disp_q;
    pend_d     = bcd_valid ? BCD : pend_q;
    pend_vld_d = pend_vld_q | bcd_valid;
    if (boundary) begin
      disp_d     = bcd_valid ? BCD : pend_vld_q ? pend_q : disp_q;
      pend_vld_d = 1'b0;
    end
  end
  assign nib = disp_q[{idx_q, 2'b00} +: 4];
  always_comb begin
    case (nib)
      4'h0:    dec = 7'h40;
      4'h1:    dec = 7'h79;
      4'h2:    dec = 7'h24;
      4'h3:    dec = 7'h30;
      4'h4:    dec = 7'h19;
      4'h5:    dec = 7'h12;
      4'h6:    dec = 7'h02;
      4'h7:    dec = 7'h78;
      4'h8:    dec = 7'h00;
      4'h9:    dec = 7'h10;
      4'hF:    dec = 7'h3F;
      default: dec = 7'h7F;
    endcase
  end
  // a digit is a leading zero when it and every higher digit are zero; digit 0 is never blanked
  assign lz_blank = blank_lz && idx_q != 2'd0 &&
                    (idx_q == 2'd3 ? disp_q[15:12] == 4'h0 :
                     idx_q == 2'd2 ? disp_q[15:8] == 8'h00 : disp_q[15:4] == 12'h000);
  assign seg_d = lz_blank ? 7'h7F : dec;
  assign an_d  = ~(4'b0001 << idx_q);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= 2'd0;
      disp_q     <= 16'h0000;
      pend_q     <= 16'h0000;
      pend_vld_q <= 1'b0;
      seg_q      <= 7'h7F;
      an_q       <= 4'hF;
      fd_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= boundary;
    end
  end
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
endmodule
